// File: rtl/cpu_pkg.sv
// Shared FSM encoding and address-region decode for the MMIO bus controller.
// Region decode is a pure function so the top only holds the parameters.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_MMIO = 2'd1,
        RGN_ERR  = 2'd2
    } region_t;

    localparam int unsigned WORD_BYTES = 4;

    // RAM wins over MMIO if the two windows are ever configured to overlap.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input logic [32:0] ram_bytes,
        input logic [31:0] base,
        input int unsigned n_out
    );
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        if (addr[1:0] != 2'b00) begin
            return RGN_ERR;
        end
        if ({1'b0, addr} < ram_bytes) begin
            return RGN_RAM;
        end
        if ((addr >= base) && (off < 33'(WORD_BYTES * n_out))) begin
            return RGN_MMIO;
        end
        return RGN_ERR;
    endfunction

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// Request/response bus between a CPU-side master and the MMIO bus controller.
// One request in flight; rsp_valid is a single-cycle strobe.
interface mmio_bus_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/bram_be.sv
// Single-port DEPTH x 32 RAM with byte enables and a registered read port.
// Read data only updates on an enabled read, so it holds through wait states.
module bram_be #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;
endmodule

// File: rtl/mmio_bus_ctrl.sv
// Decodes single requests into data RAM or output registers; response WAIT+1 cycles after acceptance.
// Writes commit on the acceptance edge; req_ready is high only while idle.
module mmio_bus_ctrl
    import cpu_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          N_OUT     = 1,
    parameter int          OUT_W     = 16,
    parameter int          WAIT      = 0,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic                   clk,
    input  logic                   rst,
    mmio_bus_ctrl_if.slave         bus,
    output logic [N_OUT*OUT_W-1:0] out_data
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t            r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rd_ram;
    logic [31:0]       r_rdata;
    logic [3:0]        r_wcnt;
    logic [OUT_W-1:0]  r_out [N_OUT];

    logic              w_accept;
    region_t           w_rgn;
    logic [3:0]        w_mmio_idx;
    logic [31:0]       w_mmio_rd;
    logic [31:0]       w_ram_q;
    logic              w_ram_en;

    assign w_accept   = bus.req_valid & r_ready & ~rst;
    assign w_rgn      = decode_region(bus.req_addr, RAM_BYTES, MMIO_BASE, N_OUT);
    assign w_mmio_idx = 4'((bus.req_addr - MMIO_BASE) >> 2);
    assign w_ram_en   = w_accept & (w_rgn == RGN_RAM);

    bram_be #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (bus.req_we),
        .i_be    (bus.req_be),
        .i_addr  (bus.req_addr[AW+1:2]),
        .i_wdata (bus.req_wdata),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_mmio_rd = 32'd0;
        for (int i = 0; i < N_OUT; i++) begin
            if (w_mmio_idx == 4'(i)) begin
                w_mmio_rd = 32'(r_out[i]);
            end
        end
    end

    // Byte enables map onto the low OUT_W bits only; wider bytes fall away.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_out[i] <= '0;
            end
        end else if (w_accept && bus.req_we && (w_rgn == RGN_MMIO)) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_mmio_idx == 4'(i)) begin
                    for (int k = 0; k < OUT_W; k++) begin
                        if (bus.req_be[k/8]) begin
                            r_out[i][k] <= bus.req_wdata[k];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ram    <= 1'b0;
            r_rdata     <= 32'd0;
            r_wcnt      <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready   <= 1'b0;
                        r_rsp_err <= (w_rgn == RGN_ERR);
                        r_rd_ram  <= ~bus.req_we & (w_rgn == RGN_RAM);
                        r_rdata   <= (~bus.req_we && (w_rgn == RGN_MMIO)) ? w_mmio_rd : 32'd0;
                        if (WAIT > 0) begin
                            r_state <= ST_WAIT;
                            r_wcnt  <= WAIT_LOAD;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rd_ram    <= 1'b0;
                    r_rdata     <= 32'd0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < N_OUT; g++) begin : g_out
            assign out_data[g*OUT_W +: OUT_W] = r_out[g];
        end
    endgenerate

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_valid & r_rsp_err;
    assign bus.rsp_rdata = !r_rsp_valid ? 32'd0 : (r_rd_ram ? w_ram_q : r_rdata);
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench: instance A (WAIT=0, one 16-bit output) and B (WAIT=3, four 8-bit outputs).
module tb_mmio_bus_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a;
    logic        rst_b;
    logic [15:0] out_a;
    logic [31:0] out_b;

    mmio_bus_ctrl_if bus_a ();
    mmio_bus_ctrl_if bus_b ();

    mmio_bus_ctrl #(.DEPTH(256), .N_OUT(1), .OUT_W(16), .WAIT(0), .MMIO_BASE(32'h0000_1000)) dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .bus      (bus_a),
        .out_data (out_a)
    );

    mmio_bus_ctrl #(.DEPTH(256), .N_OUT(4), .OUT_W(8), .WAIT(3), .MMIO_BASE(32'h0000_1000)) dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .bus      (bus_b),
        .out_data (out_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rdy_hi;
    int          seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus_b.req_ready : bus_a.req_ready;
    endfunction

    function automatic logic rspv(input bit sel);
        return sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    endfunction

    task automatic drive(input bit sel, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata; bus_a.req_be = be;
        bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wdata; bus_b.req_be = be;
        bus_a.req_valid = ~sel;
        bus_b.req_valid = sel;
    endtask

    // One full transaction: latency, ready-low window and single-cycle strobe are checked here.
    task automatic do_req(input string tag, input bit sel, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int exp_lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy(sel) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready"}, 32'(rdy(sel)), 32'd1);
        drive(sel, we, addr, wdata, be);
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        lat = 1; rdy_hi = 0; rd = 32'd0; er = 1'b0;
        while (1) begin
            if (rdy(sel)) rdy_hi++;
            if (rspv(sel)) begin
                rd = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
                er = sel ? bus_b.rsp_err : bus_a.rsp_err;
                break;
            end
            if (lat >= 40) break;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdy_low"}, 32'(rdy_hi), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_strobe"}, 32'(rspv(sel)), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_a.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_vld_a", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst_err_a", 32'(bus_a.rsp_err), 32'd0);
        chk("rst_rdata_a", bus_a.rsp_rdata, 32'd0);
        chk("rst_vld_b", 32'(bus_b.rsp_valid), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst_a", 32'(bus_a.req_ready), 32'd1);
        chk("rdy_after_rst_b", 32'(bus_b.req_ready), 32'd1);

        // ---- instance A, WAIT=0 ----
        do_req("a_wr10", 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1);
        chk("a_wr10_err", 32'(er), 32'd0);
        chk("a_wr10_rd", rd, 32'd0);
        do_req("a_rd10", 0, 0, 32'h10, 32'd0, 4'h0, 1);
        chk("a_rd10_rd", rd, 32'hDEAD_BEEF);
        chk("a_rd10_err", 32'(er), 32'd0);
        do_req("a_wrout", 0, 1, 32'h1000, 32'h1234_5678, 4'b0001, 1);
        chk("a_wrout_err", 32'(er), 32'd0);
        chk("a_out_b0", 32'(out_a), 32'h0000_0078);
        do_req("a_rdout", 0, 0, 32'h1000, 32'd0, 4'h0, 1);
        chk("a_rdout_rd", rd, 32'h0000_0078);
        do_req("a_wr0", 0, 1, 32'h0, 32'h1111_1111, 4'hF, 1);
        do_req("a_wr2", 0, 1, 32'h2, 32'hFFFF_FFFF, 4'hF, 1);
        chk("a_wr2_err", 32'(er), 32'd1);
        chk("a_wr2_rd", rd, 32'd0);
        do_req("a_rd0", 0, 0, 32'h0, 32'd0, 4'h0, 1);
        chk("a_rd0_rd", rd, 32'h1111_1111);
        chk("a_rd0_err", 32'(er), 32'd0);
        do_req("a_rd2", 0, 0, 32'h2, 32'd0, 4'h0, 1);
        chk("a_rd2_err", 32'(er), 32'd1);
        chk("a_rd2_rd", rd, 32'd0);
        do_req("a_wr1004", 0, 1, 32'h1004, 32'hFFFF_FFFF, 4'hF, 1);
        chk("a_wr1004_err", 32'(er), 32'd1);
        chk("a_out_keep", 32'(out_a), 32'h0000_0078);
        do_req("a_rd1004", 0, 0, 32'h1004, 32'd0, 4'h0, 1);
        chk("a_rd1004_err", 32'(er), 32'd1);
        chk("a_rd1004_rd", rd, 32'd0);
        do_req("a_be0", 0, 1, 32'h10, 32'h0, 4'h0, 1);
        chk("a_be0_err", 32'(er), 32'd0);
        do_req("a_rd10b", 0, 0, 32'h10, 32'd0, 4'h0, 1);
        chk("a_rd10b_rd", rd, 32'hDEAD_BEEF);
        do_req("a_part", 0, 1, 32'h10, 32'h00AB_CD00, 4'b0110, 1);
        do_req("a_rd10c", 0, 0, 32'h10, 32'd0, 4'h0, 1);
        chk("a_rd10c_rd", rd, 32'hDEAB_CDEF);
        do_req("a_rd400", 0, 0, 32'h400, 32'd0, 4'h0, 1);
        chk("a_rd400_err", 32'(er), 32'd1);
        chk("a_rd400_rd", rd, 32'd0);
        do_req("a_wrhi", 0, 1, 32'h1000, 32'hFFFF_AB00, 4'b1110, 1);
        chk("a_out_hi", 32'(out_a), 32'h0000_AB78);

        // ---- instance B, WAIT=3 ----
        do_req("b_wr2", 1, 1, 32'h1008, 32'h0000_00FF, 4'hF, 4);
        chk("b_out_r2", out_b, 32'h00FF_0000);
        do_req("b_rd2", 1, 0, 32'h1008, 32'd0, 4'h0, 4);
        chk("b_rd2_rd", rd, 32'h0000_00FF);
        chk("b_rd2_err", 32'(er), 32'd0);

        // Write to 0x20 then reset while the response is still pending.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF);
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        rst_b = 1'b1;
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus_b.rsp_valid) seen++;
        end
        rst_b = 1'b0;
        chk("b_rdy_after_rst", 32'(bus_b.req_ready), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus_b.rsp_valid) seen++;
        end
        chk("b_rst_no_rsp", 32'(seen), 32'd0);
        chk("b_rst_out", out_b, 32'd0);
        do_req("b_rd20", 1, 0, 32'h20, 32'd0, 4'h0, 4);
        chk("b_rd20_rd", rd, 32'hA5A5_A5A5);
        do_req("b_wr3", 1, 1, 32'h100C, 32'h1234_56AB, 4'hF, 4);
        chk("b_out_r3", out_b, 32'hAB00_0000);
        do_req("b_rd3", 1, 0, 32'h100C, 32'd0, 4'h0, 4);
        chk("b_rd3_rd", rd, 32'h0000_00AB);
        do_req("b_rd1010", 1, 0, 32'h1010, 32'd0, 4'h0, 4);
        chk("b_rd1010_err", 32'(er), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmio_bus_ctrl.md
MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, data RAM size in 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter N_OUT, default 1, number of memory-mapped output registers (1..16).
REQ-003 SHALL have parameter OUT_W, default 16, width of each output register (1..32).
REQ-004 SHALL have parameter WAIT, default 0, extra wait-state cycles per access (0..15).
REQ-005 SHALL have parameter MMIO_BASE, default 32'h0000_1000, byte address of output register 0.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  controller can accept a request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  write data.
REQ-013 req_be  input  4  byte enables for writes, bit i selects byte i.
REQ-014 rsp_valid  output  1  one-cycle response strobe.
REQ-015 rsp_rdata  output  32  read data, valid with rsp_valid; 0 for writes and errors.
REQ-016 rsp_err  output  1  decode or alignment error, valid with rsp_valid.
REQ-017 out_data  output  N_OUT*OUT_W  concatenated output registers, register i at bits [i*OUT_W +: OUT_W].

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-019 SHALL drive req_ready = 1 only in IDLE.
REQ-020 Request SHALL be accepted on a cycle with req_valid && req_ready; addr, we, wdata and be are captured on that edge.
REQ-021 On acceptance, SHALL go to WAIT when WAIT > 0, otherwise to RESP.
REQ-022 WAIT SHALL count exactly WAIT cycles, then go to RESP.
REQ-023 RESP SHALL last exactly one cycle with rsp_valid = 1, then return to IDLE.
REQ-024 Latency from acceptance edge to rsp_valid high SHALL be WAIT+1 cycles; maximum throughput is one request per WAIT+2 cycles.
REQ-025 RAM region SHALL be byte addresses 0 .. DEPTH*4-1, word index req_addr[log2(DEPTH)+1:2].
REQ-026 MMIO region SHALL be MMIO_BASE + 4*i for i < N_OUT.
REQ-027 Any other address, or req_addr[1:0] != 0, SHALL give rsp_err = 1 and rsp_rdata = 0, with no state change.
REQ-028 Writes SHALL commit on the acceptance edge; only enabled bytes change; be = 4'b0000 is a legal no-op with no error.
REQ-029 Output register writes SHALL apply the byte enables to the low OUT_W bits; bits at or above OUT_W are ignored.
REQ-030 Reads SHALL return the RAM word, or the output register zero-extended to 32 bits, as of the acceptance edge.
REQ-031 Reading an address written by the immediately preceding request SHALL return the new data.
REQ-032 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-033 While rst is high, the FSM SHALL enter IDLE on the next edge; rsp_valid, rsp_err and rsp_rdata SHALL be 0; every output register SHALL be 0, so out_data = 0.
REQ-034 RAM contents SHALL NOT be reset.
REQ-035 Reset during WAIT or RESP SHALL drop the pending response; a write already committed at acceptance SHALL remain.
REQ-036 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-037 FSM state encoding and region-decode constants SHALL live in a shared package cpu_pkg.
REQ-038 The data RAM SHALL be a sub-module bram_be: single port, byte-enabled, synchronous read, DEPTH x 32.
REQ-039 Decode, FSM, wait counter and output registers SHALL stay in mmio_bus_ctrl.

Verification
REQ-040 WAIT=0: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rsp_valid 1 cycle after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-041 WAIT=3: read accepted at cycle t -> rsp_valid exactly at t+4; req_ready low for cycles t+1 .. t+4.
REQ-042 Write 0x12345678 to MMIO_BASE with be=4'b0001, OUT_W=16, prior value 0 -> out_data[15:0] = 0x0078.
REQ-043 Access to address 0x0000_0002, or to MMIO_BASE + 4*N_OUT -> rsp_err 1, rdata 0, no RAM or output register change.
REQ-044 Reset asserted while in WAIT after a write to 0x20 of 0xA5A5A5A5 -> no rsp_valid, out_data 0, later read of 0x20 returns 0xA5A5A5A5.
REQ-045 N_OUT=4, OUT_W=8: write 0xFF to register 2 -> out_data = 32'h00FF_0000.
